// File: rtl/register_write_arbiter_pkg.sv
// Shared constants for the register write arbiter.
// These match the 16 x 20-bit register bank that the arbiter drives.
package register_write_arbiter_pkg;

    localparam int RWA_NREQ = 3;
    localparam int RWA_AW   = 4;
    localparam int RWA_DW   = 20;
    localparam int RWA_IDW  = 2;

    // Increments a requester index and wraps it modulo n.
    function automatic logic [RWA_IDW-1:0] rr_wrap_inc(input logic [RWA_IDW-1:0] idx, input int n);
        return (int'(idx) + 1 >= n) ? '0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/register_write_arbiter_rr_priority_pick.sv
// Combinational round-robin picker.
// It returns the first eligible requester at or after ptr, in wrapping order.
module rr_priority_pick
    import register_write_arbiter_pkg::*;
#(
    parameter int NREQ = RWA_NREQ
) (
    input  logic [NREQ-1:0]    eligible,
    input  logic [RWA_IDW-1:0] ptr,
    output logic [RWA_IDW-1:0] winner,
    output logic               found
);

    always_comb begin
        int                 idx;
        logic [RWA_IDW-1:0] sel;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            sel = RWA_IDW'(idx);
            if (!found && eligible[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
    end

endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin write arbiter in front of the 20-bit register bank.
// The outputs are registered. The ack pulse masks the requester that was just
// granted, so that requester is not granted again on the next edge.
module register_write_arbiter
    import register_write_arbiter_pkg::*;
#(
    parameter int NREQ = RWA_NREQ,
    parameter int AW   = RWA_AW,
    parameter int DW   = RWA_DW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 stall,
    output logic [NREQ-1:0]      ack,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [DW-1:0]        wr_data,
    output logic [RWA_IDW-1:0]   grant_id
);

    logic [NREQ-1:0]    eligible;
    logic [NREQ-1:0]    win_onehot;
    logic [RWA_IDW-1:0] ptr;
    logic [RWA_IDW-1:0] winner;
    logic               found;
    logic               grant;

    assign eligible   = req & ~ack;
    assign grant      = found & ~stall;
    assign win_onehot = NREQ'(1) << winner;

    rr_priority_pick #(.NREQ(NREQ)) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .winner   (winner),
        .found    (found)
    );

    // wr_addr, wr_data and grant_id keep their last values while no grant is made.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            grant_id <= '0;
            ptr      <= '0;
        end else begin
            wr_en <= grant;
            ack   <= grant ? win_onehot : '0;
            if (grant) begin
                grant_id <= winner;
                wr_addr  <= req_addr[int'(winner)*AW +: AW];
                wr_data  <= req_data[int'(winner)*DW +: DW];
                ptr      <= rr_wrap_inc(winner, NREQ);
            end
        end
    end

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed bench for register_write_arbiter.
// Expected results are queued when each step is driven and checked one cycle later.
module tb_register_write_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [11:0] req_addr;
    logic [59:0] req_data;
    logic        stall;
    logic [2:0]  ack;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [19:0] wr_data;
    logic [1:0]  grant_id;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        we;
        logic [2:0]  ack;
        logic [1:0]  gid;
        logic [3:0]  addr;
        logic [19:0] data;
        logic [1:0]  ptr;
    } exp_t;

    exp_t exp_q[$];

    register_write_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .stall    (stall),
        .ack      (ack),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .grant_id (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic [2:0] r, input logic s, input logic we, input logic [2:0] a,
                        input logic [1:0] g, input logic [3:0] ad, input logic [19:0] d,
                        input logic [1:0] p);
        exp_t e;
        req   = r;
        stall = s;
        e.we = we; e.ack = a; e.gid = g; e.addr = ad; e.data = d; e.ptr = p;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("wr_en", 32'(wr_en), 32'(e.we));
        chk("ack", 32'(ack), 32'(e.ack));
        if (e.we) chk("grant_id", 32'(grant_id), 32'(e.gid));
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
        chk("ptr", 32'(dut.ptr), 32'(e.ptr));
    endtask

    initial begin
        reset    = 1'b0;
        req      = '0;
        stall    = 1'b0;
        req_addr = {4'h9, 4'h5, 4'h3};
        req_data = {20'd77, 20'd54, 20'd45};
        #3;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_data", 32'(wr_data), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_ptr", 32'(dut.ptr), 32'd0);
        #4;
        reset = 1'b1;

        // First grant after reset: a single requester 0.
        step(3'b001, 0, 1, 3'b001, 0, 4'h3, 20'd45, 2'd1);
        step(3'b100, 0, 1, 3'b100, 2, 4'h9, 20'd77, 2'd0);
        step(3'b000, 0, 0, 3'b000, 0, 4'h9, 20'd77, 2'd0);

        // All three requesters held continuously.
        step(3'b111, 0, 1, 3'b001, 0, 4'h3, 20'd45, 2'd1);
        step(3'b111, 0, 1, 3'b010, 1, 4'h5, 20'd54, 2'd2);
        step(3'b111, 0, 1, 3'b100, 2, 4'h9, 20'd77, 2'd0);
        step(3'b111, 0, 1, 3'b001, 0, 4'h3, 20'd45, 2'd1);
        step(3'b111, 0, 1, 3'b010, 1, 4'h5, 20'd54, 2'd2);
        step(3'b111, 0, 1, 3'b100, 2, 4'h9, 20'd77, 2'd0);
        step(3'b000, 0, 0, 3'b000, 0, 4'h9, 20'd77, 2'd0);

        // req=110 with ptr=0: requester 1 first, then 2.
        step(3'b110, 0, 1, 3'b010, 1, 4'h5, 20'd54, 2'd2);
        step(3'b110, 0, 1, 3'b100, 2, 4'h9, 20'd77, 2'd0);
        step(3'b000, 0, 0, 3'b000, 0, 4'h9, 20'd77, 2'd0);

        // A stall blocks grants. The pending request is served once the stall falls.
        step(3'b010, 1, 0, 3'b000, 0, 4'h9, 20'd77, 2'd0);
        step(3'b010, 1, 0, 3'b000, 0, 4'h9, 20'd77, 2'd0);
        step(3'b010, 1, 0, 3'b000, 0, 4'h9, 20'd77, 2'd0);
        step(3'b010, 0, 1, 3'b010, 1, 4'h5, 20'd54, 2'd2);
        step(3'b000, 0, 0, 3'b000, 0, 4'h5, 20'd54, 2'd2);

        // req0 withdrawn during a stall is never acknowledged.
        step(3'b001, 1, 0, 3'b000, 0, 4'h5, 20'd54, 2'd2);
        step(3'b000, 1, 0, 3'b000, 0, 4'h5, 20'd54, 2'd2);
        step(3'b000, 0, 0, 3'b000, 0, 4'h5, 20'd54, 2'd2);

        // ptr=2 wraps the search order to 2, 0, 1.
        step(3'b011, 0, 1, 3'b001, 0, 4'h3, 20'd45, 2'd1);
        step(3'b011, 0, 1, 3'b010, 1, 4'h5, 20'd54, 2'd2);
        step(3'b000, 0, 0, 3'b000, 0, 4'h5, 20'd54, 2'd2);
        step(3'b010, 0, 1, 3'b010, 1, 4'h5, 20'd54, 2'd2);

        // Reset asserted mid-cycle while wr_en=1.
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_ptr", 32'(dut.ptr), 32'd0);
        chk("mid_rst_data", 32'(wr_data), 32'd0);
        #1;
        reset = 1'b1;

        step(3'b110, 0, 1, 3'b010, 1, 4'h5, 20'd54, 2'd2);
        step(3'b100, 0, 1, 3'b100, 2, 4'h9, 20'd77, 2'd0);
        step(3'b000, 0, 0, 3'b000, 0, 4'h9, 20'd77, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
